// File: rtl/alu_result_stage_pkg.sv
// ============================================================================
// Module  : alu_result_stage_pkg
// Brief   : Shared types for the ALU result stage: condition codes, status
//           bit positions and the stage state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_result_stage_pkg;

  localparam int STATUS_C = 3;
  localparam int STATUS_Z = 2;
  localparam int STATUS_N = 1;
  localparam int STATUS_V = 0;

  typedef logic [3:0] t_status;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } t_cond;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_FULL2 = 2'd2
  } t_state;

endpackage

`default_nettype wire

// File: rtl/alu_result_stage_cond_eval.sv
// ============================================================================
// Module  : alu_result_stage_cond_eval
// Brief   : Combinational evaluation of a condition code over {C,Z,N,V}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_stage_cond_eval
  import alu_result_stage_pkg::*;
(
  input  logic [3:0] status,
  input  logic [3:0] cond,
  output logic       cond_true
);

  logic w_c;
  logic w_z;
  logic w_n;
  logic w_v;

  assign w_c = status[STATUS_C];
  assign w_z = status[STATUS_Z];
  assign w_n = status[STATUS_N];
  assign w_v = status[STATUS_V];

  always_comb begin
    cond_true = 1'b0;
    case (t_cond'(cond))
      COND_EQ: cond_true = w_z;
      COND_NE: cond_true = !w_z;
      COND_CS: cond_true = w_c;
      COND_CC: cond_true = !w_c;
      COND_MI: cond_true = w_n;
      COND_PL: cond_true = !w_n;
      COND_VS: cond_true = w_v;
      COND_VC: cond_true = !w_v;
      COND_HI: cond_true = w_c & !w_z;
      COND_LS: cond_true = !w_c | w_z;
      COND_GE: cond_true = (w_n == w_v);
      COND_LT: cond_true = (w_n != w_v);
      COND_GT: cond_true = !w_z & (w_n == w_v);
      COND_LE: cond_true = w_z | (w_n != w_v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ============================================================================
// Module  : alu_result_stage
// Brief   : ALU result register, CZNV status owner and writeback handshake.
//           Define ALU_RESULT_STAGE_SKID_EN to add a one-entry skid buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter logic [3:0] RESET_STATUS = 4'b0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_carry,
  input  logic        in_zero,
  input  logic        in_neg,
  input  logic        in_over,
  input  logic        in_flags_we,
  input  logic        in_reg_we,
  input  logic [3:0]  in_dest,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_reg_we,
  output logic [3:0]  out_dest,
  input  logic        flush,
  input  logic        status_load,
  input  logic [3:0]  status_data,
  output logic [3:0]  status,
  output logic        carry_in,
  input  logic [3:0]  cond,
  output logic        cond_true
);

  t_state      r_state;
  t_state      w_state_next;
  t_status     r_status;
  logic [31:0] r_out_result;
  logic        r_out_reg_we;
  logic [3:0]  r_out_dest;
  logic        w_accept;
  logic        w_deliver;
  logic        w_load_out;

`ifdef ALU_RESULT_STAGE_SKID_EN
  logic [31:0] r_skid_result;
  logic        r_skid_reg_we;
  logic [3:0]  r_skid_dest;
  logic        w_load_skid;
  logic        w_drain_skid;

  // Skid occupancy is state FULL2, so in_ready comes straight from a flop.
  assign in_ready = (r_state != ST_FULL2);
`else
  assign in_ready = (r_state == ST_EMPTY) | out_ready;
`endif

  assign out_valid  = (r_state != ST_EMPTY);
  assign w_accept   = in_valid & in_ready & !flush;
  assign w_deliver  = out_valid & out_ready;
  assign out_result = r_out_result;
  assign out_reg_we = r_out_reg_we;
  assign out_dest   = r_out_dest;
  assign status     = r_status;
  assign carry_in   = r_status[STATUS_C];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_out   = 1'b0;
`ifdef ALU_RESULT_STAGE_SKID_EN
    w_load_skid  = 1'b0;
    w_drain_skid = 1'b0;
`endif
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_FULL;
            w_load_out   = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_accept && w_deliver) begin
            w_load_out = 1'b1;
          end else if (w_deliver) begin
            w_state_next = ST_EMPTY;
`ifdef ALU_RESULT_STAGE_SKID_EN
          end else if (w_accept) begin
            w_state_next = ST_FULL2;
            w_load_skid  = 1'b1;
`endif
          end
        end
`ifdef ALU_RESULT_STAGE_SKID_EN
        ST_FULL2: begin
          if (w_deliver) begin
            w_state_next = ST_FULL;
            w_drain_skid = 1'b1;
          end
        end
`endif
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Payload only moves on load/drain, so it stays put while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_result <= 32'd0;
      r_out_reg_we <= 1'b0;
      r_out_dest   <= 4'd0;
    end else if (w_load_out) begin
      r_out_result <= in_result;
      r_out_reg_we <= in_reg_we;
      r_out_dest   <= in_dest;
`ifdef ALU_RESULT_STAGE_SKID_EN
    end else if (w_drain_skid) begin
      r_out_result <= r_skid_result;
      r_out_reg_we <= r_skid_reg_we;
      r_out_dest   <= r_skid_dest;
`endif
    end
  end

`ifdef ALU_RESULT_STAGE_SKID_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_skid_result <= 32'd0;
      r_skid_reg_we <= 1'b0;
      r_skid_dest   <= 4'd0;
    end else if (w_load_skid) begin
      r_skid_result <= in_result;
      r_skid_reg_we <= in_reg_we;
      r_skid_dest   <= in_dest;
    end
  end
`endif

  // An interrupt restore overrides any flag update from the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_status <= RESET_STATUS;
    end else if (status_load) begin
      r_status <= status_data;
    end else if (w_accept && in_flags_we) begin
      r_status <= {in_carry, in_zero, in_neg, in_over};
    end
  end

  alu_result_stage_cond_eval u_cond_eval (
    .status    (r_status),
    .cond      (cond),
    .cond_true (cond_true)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
// Module  : tb_alu_result_stage
// Brief   : Directed and random checks of alu_result_stage against a
//           queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_stage;

  typedef struct {
    logic [31:0] result;
    logic        reg_we;
    logic [3:0]  dest;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_carry;
  logic        in_zero;
  logic        in_neg;
  logic        in_over;
  logic        in_flags_we;
  logic        in_reg_we;
  logic [3:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_reg_we;
  logic [3:0]  out_dest;
  logic        flush;
  logic        status_load;
  logic [3:0]  status_data;
  logic [3:0]  status;
  logic        carry_in;
  logic [3:0]  cond;
  logic        cond_true;

  beat_t       q[$];
  logic [3:0]  m_status;
  int          n_checks;
  int          n_pass;

  always #5 clock = ~clock;

  alu_result_stage #(.RESET_STATUS(4'b1010)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_carry    (in_carry),
    .in_zero     (in_zero),
    .in_neg      (in_neg),
    .in_over     (in_over),
    .in_flags_we (in_flags_we),
    .in_reg_we   (in_reg_we),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_reg_we  (out_reg_we),
    .out_dest    (out_dest),
    .flush       (flush),
    .status_load (status_load),
    .status_data (status_data),
    .status      (status),
    .carry_in    (carry_in),
    .cond        (cond),
    .cond_true   (cond_true)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Bit k of the table is the truth of condition code k.
  function automatic logic model_cond(input logic [3:0] s, input logic [3:0] cd);
    logic c, z, n, v;
    logic [15:0] tbl;
    c = s[3]; z = s[2]; n = s[1]; v = s[0];
    tbl = {1'b0, 1'b1, z | (n ^ v), !z & !(n ^ v), n ^ v, !(n ^ v),
           !c | z, c & !z, !v, v, !n, n, !c, c, !z, z};
    return tbl[cd];
  endfunction

  function automatic logic model_in_ready(input logic ordy);
`ifdef ALU_RESULT_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || ordy;
`endif
  endfunction

  task automatic set_idle();
    in_valid = 0; flush = 0; status_load = 0; in_flags_we = 0; out_ready = 1;
    in_carry = 0; in_zero = 0; in_neg = 0; in_over = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    logic  acc, del;
    beat_t b;
    logic [3:0] nxt_status;
    #1;
    check({tag, "_out_valid"}, out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check({tag, "_out_result"}, out_result, q[0].result);
      check({tag, "_out_reg_we"}, out_reg_we, q[0].reg_we);
      check({tag, "_out_dest"}, out_dest, q[0].dest);
    end
    check({tag, "_status"}, status, m_status);
    check({tag, "_carry_in"}, carry_in, m_status[3]);
    check({tag, "_in_ready"}, in_ready, model_in_ready(out_ready));
    check({tag, "_cond_true"}, cond_true, model_cond(m_status, cond));
    acc = in_valid && model_in_ready(out_ready) && !flush;
    del = (q.size() > 0) && out_ready;
    b.result = in_result; b.reg_we = in_reg_we; b.dest = in_dest;
    nxt_status = m_status;
    if (status_load) nxt_status = status_data;
    else if (acc && in_flags_we) nxt_status = {in_carry, in_zero, in_neg, in_over};
    @(posedge clock);
    if (flush) q.delete();
    else begin
      if (del) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    m_status = nxt_status;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_pass = 0; m_status = 4'hA;
    reset = 1; set_idle();
    in_result = 0; in_reg_we = 0; in_dest = 0; status_data = 0; cond = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    #1;
    check("rst_status", status, 4'hA);
    check("rst_carry_in", carry_in, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_out_dest", out_dest, 0);
    check("rst_out_reg_we", out_reg_we, 0);

    // Zero result sets Z and satisfies EQ.
    in_valid = 1; in_result = 32'h0; in_zero = 1; in_flags_we = 1; in_dest = 3; in_reg_we = 1;
    cycle("zr");
    set_idle(); cond = 4'd0; #1;
    check("zr_valid", out_valid, 1);
    check("zr_result", out_result, 32'h0);
    check("zr_dest", out_dest, 3);
    check("zr_status", status, 4'b0100);
    check("zr_eq", cond_true, 1);
    cycle("zr_drain");

    // Stall for three cycles with a second beat waiting.
    in_valid = 1; in_result = 32'hDEAD_BEEF; in_dest = 5; out_ready = 0;
    cycle("hold_acc");
    in_result = 32'h1234_5678; in_dest = 6;
    for (int i = 0; i < 3; i++) begin
      cycle("hold");
      check("hold_result", out_result, 32'hDEAD_BEEF);
      check("hold_dest", out_dest, 5);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    cycle("hold_rel");
    #1;
`ifdef ALU_RESULT_STAGE_SKID_EN
    check("skid_valid", out_valid, 1);
    check("skid_result", out_result, 32'h1234_5678);
`else
    check("noskid_valid", out_valid, 0);
`endif
    cycle("hold_drain");

    // Status restore wins over a flag-updating accept.
    in_valid = 1; in_carry = 1; in_flags_we = 1; in_result = 32'h55; in_dest = 7;
    status_load = 1; status_data = 4'b0001;
    cycle("sl");
    set_idle(); #1;
    check("sl_status", status, 4'b0001);
    check("sl_valid", out_valid, 1);
    check("sl_result", out_result, 32'h55);
    cycle("sl_drain");

    // Carry chain, then signed compare flags.
    in_valid = 1; in_carry = 1; in_flags_we = 1; in_result = 32'h1; in_dest = 1;
    cycle("addc1");
    check("addc_carry_in", carry_in, 1);
    in_carry = 0; in_neg = 1; in_over = 0; in_result = 32'h8000_0000; in_dest = 2;
    cycle("addc2");
    set_idle(); cond = 4'd11; #1;
    check("lt_true", cond_true, 1);
    cond = 4'd10; #1;
    check("ge_false", cond_true, 0);
    cycle("addc_drain");

    // Flush while holding a beat, with a competing flag-updating input.
    in_valid = 1; in_result = 32'hAAAA; in_dest = 9; out_ready = 0;
    cycle("fl_fill");
    in_result = 32'hBBBB; in_flags_we = 1; in_carry = 1; in_zero = 1; flush = 1;
    cycle("fl");
    set_idle(); #1;
    check("fl_valid", out_valid, 0);
    check("fl_status", status, 4'b0010);
    cycle("fl_idle");

    repeat (400) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 19) == 0);
      status_load = ($urandom_range(0, 19) == 0);
      status_data = 4'($urandom_range(0, 15));
      in_flags_we = 1'($urandom_range(0, 1));
      in_reg_we   = 1'($urandom_range(0, 1));
      in_carry    = 1'($urandom_range(0, 1));
      in_zero     = 1'($urandom_range(0, 1));
      in_neg      = 1'($urandom_range(0, 1));
      in_over     = 1'($urandom_range(0, 1));
      in_result   = $urandom;
      in_dest     = 4'($urandom_range(0, 15));
      cond        = 4'($urandom_range(0, 15));
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
